id_ex_stage: RTL

- ID/EX pipeline register and operand-select stage of the pipelined RV64 core; sits directly upstream of the 64-bit ALU.
- Captures decoded operands and control from ID and decodes the 4-bit ALU control code.
- Applies EX/MEM and MEM/WB forwarding and presents alu_a, alu_b and alu_ctrl to the ALU.
- Handles valid/ready flow control, flush, and load-use stall detection.

---
 rtl/id_ex_if.sv | 69 ++++++
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/id_ex_if.sv
`default_nettype none
// ==== id_ex_if : ID -> EX stage bus (decode side, forwarding sources, ALU side) -- rev 1.0 ====
interface id_ex_if #(
  parameter int XLEN = 64,
  parameter int RW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [RW-1:0]   rs1_addr;
  logic [RW-1:0]   rs2_addr;
  logic [RW-1:0]   rd_addr;
  logic [2:0]      funct3;
  logic            funct7_30;
  logic [1:0]      alu_class;
  logic            alu_src;
  logic            mem_read;
  logic            mem_write;
  logic            reg_write;
  logic            mem_to_reg;
  logic            branch;
  logic            flush;
  logic            exmem_reg_write;
  logic            memwb_reg_write;
  logic [RW-1:0]   exmem_rd;
  logic [RW-1:0]   memwb_rd;
  logic [XLEN-1:0] exmem_result;
  logic [XLEN-1:0] memwb_result;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] store_data;
  logic [3:0]      alu_ctrl;
  logic [RW-1:0]   rd_out;
  logic            mem_read_o;
  logic            mem_write_o;
  logic            reg_write_o;
  logic            mem_to_reg_o;
  logic            branch_o;
  logic            illegal_op;
  logic            load_use_stall;

  modport master (
    output in_valid, rs1_data, rs2_data, imm, rs1_addr, rs2_addr, rd_addr,
           funct3, funct7_30, alu_class, alu_src, mem_read, mem_write,
           reg_write, mem_to_reg, branch, flush,
           exmem_reg_write, memwb_reg_write, exmem_rd, memwb_rd,
           exmem_result, memwb_result, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, store_data, alu_ctrl, rd_out,
           mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o, branch_o,
           illegal_op, load_use_stall
  );

  modport slave (
    input  in_valid, rs1_data, rs2_data, imm, rs1_addr, rs2_addr, rd_addr,
           funct3, funct7_30, alu_class, alu_src, mem_read, mem_write,
           reg_write, mem_to_reg, branch, flush,
           exmem_reg_write, memwb_reg_write, exmem_rd, memwb_rd,
           exmem_result, memwb_result, out_ready,
    output in_ready, out_valid, alu_a, alu_b, store_data, alu_ctrl, rd_out,
           mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o, branch_o,
           illegal_op, load_use_stall
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ==== id_ex_stage : ID/EX pipeline register, ALU-control decode, EX/MEM + MEM/WB forwarding -- rev 1.0 ====
module id_ex_stage #(
  parameter int XLEN = 64,
  parameter int RW   = 5
) (
  input  logic   clk,
  input  logic   reset,
  id_ex_if.slave bus
);

  localparam logic [3:0] c_ALU_AND = 4'b0000;
  localparam logic [3:0] c_ALU_OR  = 4'b0001;
  localparam logic [3:0] c_ALU_ADD = 4'b0010;
  localparam logic [3:0] c_ALU_SLL = 4'b0100;
  localparam logic [3:0] c_ALU_SUB = 4'b0110;

  logic            r_valid;
  logic [RW-1:0]   r_rs1_addr;
  logic [RW-1:0]   r_rs2_addr;
  logic [RW-1:0]   r_rd;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [3:0]      r_alu_ctrl;
  logic            r_illegal;
  logic            r_alu_src;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_reg_write;
  logic            r_mem_to_reg;
  logic            r_branch;

  logic            w_load_use;
  logic            w_in_ready;
  logic            w_capture;
  logic [3:0]      w_ctrl;
  logic            w_illegal;
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;

  // A held load whose rd feeds the incoming instruction must drain before that instruction enters.
  assign w_load_use = r_valid & r_mem_read & (r_rd != '0) &
                      ((r_rd == bus.rs1_addr) | (r_rd == bus.rs2_addr)) & bus.in_valid;
  assign w_in_ready = (~r_valid | bus.out_ready) & ~w_load_use;
  assign w_capture  = bus.in_valid & w_in_ready & ~bus.flush;

  always_comb begin
    w_ctrl    = c_ALU_ADD;
    w_illegal = 1'b0;
    case (bus.alu_class)
      2'b00: w_ctrl = c_ALU_ADD;
      2'b01: w_ctrl = c_ALU_SUB;
      2'b10: begin
        case (bus.funct3)
          3'b000:  w_ctrl = (bus.funct7_30 && !bus.alu_src) ? c_ALU_SUB : c_ALU_ADD;
          3'b111:  w_ctrl = c_ALU_AND;
          3'b110:  w_ctrl = c_ALU_OR;
          3'b001:  w_ctrl = c_ALU_SLL;
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_rs1_addr   <= '0;
      r_rs2_addr   <= '0;
      r_rd         <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_alu_ctrl   <= c_ALU_ADD;
      r_illegal    <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid      <= 1'b1;
      r_rs1_addr   <= bus.rs1_addr;
      r_rs2_addr   <= bus.rs2_addr;
      r_rd         <= bus.rd_addr;
      r_rs1_data   <= bus.rs1_data;
      r_rs2_data   <= bus.rs2_data;
      r_imm        <= bus.imm;
      r_alu_ctrl   <= w_ctrl;
      r_illegal    <= w_illegal;
      r_alu_src    <= bus.alu_src;
      r_mem_read   <= bus.mem_read;
      r_mem_write  <= bus.mem_write;
      r_reg_write  <= bus.reg_write;
      r_mem_to_reg <= bus.mem_to_reg;
      r_branch     <= bus.branch;
    end else if (r_valid && bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is hard-wired and never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RW-1:0]   src_addr,
    input logic [XLEN-1:0] src_data,
    input logic            ex_we,
    input logic [RW-1:0]   ex_rd,
    input logic [XLEN-1:0] ex_val,
    input logic            wb_we,
    input logic [RW-1:0]   wb_rd,
    input logic [XLEN-1:0] wb_val
  );
    if (ex_we && (ex_rd != '0) && (ex_rd == src_addr)) return ex_val;
    if (wb_we && (wb_rd != '0) && (wb_rd == src_addr)) return wb_val;
    return src_data;
  endfunction

  assign w_fwd_rs1 = fwd_sel(r_rs1_addr, r_rs1_data,
                             bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                             bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
  assign w_fwd_rs2 = fwd_sel(r_rs2_addr, r_rs2_data,
                             bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                             bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);

  assign bus.in_ready       = w_in_ready;
  assign bus.load_use_stall = w_load_use;
  assign bus.out_valid      = r_valid;
  assign bus.alu_a          = w_fwd_rs1;
  assign bus.alu_b          = r_alu_src ? r_imm : w_fwd_rs2;
  assign bus.store_data     = w_fwd_rs2;
  assign bus.alu_ctrl       = r_alu_ctrl;
  assign bus.illegal_op     = r_illegal;
  assign bus.rd_out         = r_rd;
  assign bus.mem_read_o     = r_mem_read;
  assign bus.mem_write_o    = r_mem_write;
  assign bus.reg_write_o    = r_reg_write;
  assign bus.mem_to_reg_o   = r_mem_to_reg;
  assign bus.branch_o       = r_branch;

endmodule

`default_nettype wire
